// File: rtl/apb_master.sv
// ----------------------------------------------------------------------------
// apb_master
//   Takes one command at a time from a valid/ready command port. It runs the
//   command as a single APB transfer (SETUP then ACCESS). It then returns the
//   outcome on a valid/ready response port.
//
// Handshake rule, used on both the command and the response port:
//   A beat transfers on a rising PCLK edge where valid and ready are both 1.
//   The producer holds valid and its payload stable until that edge.
//   The consumer may raise or lower ready at any time.
//   cmd_ready_o is a decode of the registered state only, so it never
//   depends combinationally on cmd_valid_i.
//
// Parameters
//   ADDR_WIDTH      APB / command address width
//   DATA_WIDTH      APB / command data width
//   TIMEOUT_CYCLES  number of ACCESS cycles with PREADY low before the
//                   transfer is aborted (>= 1)
//
// Ports
//   PCLK, PRESETn           clock, synchronous active-low reset
//   cmd_valid_i/ready_o     command handshake
//   cmd_write_i/addr_i/wdata_i  command payload
//   rsp_valid_o/ready_i     response handshake
//   rsp_rdata_o/err_o/timeout_o response payload
//   PSEL..PWDATA            APB requester outputs, all straight from flops
//   PRDATA, PREADY, PSLVERR APB completer inputs
//   dbg_state               current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
// ----------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [1:0]            dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] wait_cnt;

    logic cmd_fire;
    logic xfer_done;
    logic xfer_abort;
    logic last_wait;
    logic psel_d;
    logic penable_d;
    logic rsp_valid_d;

    // wait_cnt holds the number of PREADY-low ACCESS cycles already seen.
    // A PREADY-low cycle when wait_cnt is TIMEOUT_CYCLES-1 brings the count
    // to TIMEOUT_CYCLES, which aborts the transfer. PREADY high on that same
    // cycle still completes normally, because xfer_done is checked first.
    assign last_wait  = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign cmd_fire   = (state == S_IDLE) && cmd_valid_i;
    assign xfer_done  = (state == S_ACCESS) && PREADY;
    assign xfer_abort = (state == S_ACCESS) && !PREADY && last_wait;

    // ---------------- state register ----------------
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (cmd_valid_i) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_ACCESS;
            S_ACCESS: if (xfer_done || xfer_abort) state_nx = S_RESP;
            S_RESP:   if (rsp_ready_i) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // The APB strobes and rsp_valid_o are decoded from the next state and
    // then registered. This keeps the pins flop-driven, and they still line
    // up with the state they belong to.
    always_comb begin
        cmd_ready_o = (state == S_IDLE);
        dbg_state   = state;
        psel_d      = (state_nx == S_SETUP) || (state_nx == S_ACCESS);
        penable_d   = (state_nx == S_ACCESS);
        rsp_valid_d = (state_nx == S_RESP);
    end

    // ---------------- APB strobes and wait counter ----------------
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid_o <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            rsp_valid_o <= rsp_valid_d;
            if (state == S_SETUP) begin
                wait_cnt <= '0;
            end else if ((state == S_ACCESS) && !PREADY && !last_wait) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    // ---------------- command capture ----------------
    // Address, direction and write data are loaded only on acceptance.
    // They hold through the transfer and afterwards, until the next command.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (cmd_fire) begin
            PWRITE <= cmd_write_i;
            PADDR  <= cmd_addr_i;
            PWDATA <= cmd_wdata_i;
        end
    end

    // ---------------- response capture ----------------
    // PRDATA and PSLVERR are sampled only on a completing ACCESS cycle.
    // The response fields then hold through RESP.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else if (xfer_done) begin
            rsp_rdata_o   <= PWRITE ? '0 : PRDATA;
            rsp_err_o     <= PSLVERR;
            rsp_timeout_o <= 1'b0;
        end else if (xfer_abort) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [1:0]    dbg_state;

    // ---------------- clock / reset ----------------
    always #5 PCLK = ~PCLK;

    apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW+1:0] exp_q[$];   // {rdata, err, timeout}

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;     // PREADY-low ACCESS cycles before PREADY rises
        logic [DW-1:0] prdata;
        logic          slverr;
        int            hold;      // cycles rsp_ready_i stays low in RESP
        logic [DW-1:0] e_rdata;
        logic          e_err;
        logic          e_to;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int waits,
                                input logic [DW-1:0] prdata, input logic slverr,
                                input int hold, input logic [DW-1:0] e_rdata,
                                input logic e_err, input logic e_to);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits;
        v.prdata = prdata; v.slverr = slverr; v.hold = hold;
        v.e_rdata = e_rdata; v.e_err = e_err; v.e_to = e_to;
        return v;
    endfunction

    // Reference outcome of one transfer. The completer raises PREADY on
    // ACCESS cycle waits+1. That happens only if the limit of TO ACCESS
    // cycles has not already been used up.
    function automatic logic [DW+1:0] model(input vec_t v);
        logic [DW-1:0] rd;
        if (v.waits >= TO) begin
            rd = '0;
            return {rd, 1'b1, 1'b1};
        end
        rd = v.wr ? '0 : v.prdata;
        return {rd, v.slverr, 1'b0};
    endfunction

    function automatic int model_access_cycles(input vec_t v);
        return (v.waits >= TO) ? TO : v.waits + 1;
    endfunction

    task automatic do_reset();
        PRESETn = 1'b0;
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        PREADY = 1'b0;
        step();
        step();
        PRESETn = 1'b1;
    endtask

    // One full command -> APB transfer -> response, checked along the way
    task automatic run_xfer(input string tag, input vec_t v, input logic [DW+1:0] e);
        int            lat;
        int            acc;
        logic          got;
        logic          stable_ok;
        logic [DW+1:0] ex;
        logic [DW-1:0] h_rd;
        logic          h_err;
        logic          h_to;

        exp_q.push_back(e);
        chk({tag, "_cmd_ready_idle"}, cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_write_i = v.wr;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        PREADY      = 1'b0;
        PRDATA      = $urandom;
        PSLVERR     = 1'($urandom_range(0, 1));
        step();                               // accept edge N
        cmd_valid_i = 1'b0;
        cmd_write_i = ~v.wr;                  // scramble: DUT must use captured copy
        cmd_addr_i  = $urandom;
        cmd_wdata_i = $urandom;
        chk({tag, "_setup_psel"}, PSEL, 1);
        chk({tag, "_setup_penable"}, PENABLE, 0);
        chk({tag, "_paddr"}, PADDR, v.addr);
        chk({tag, "_pwrite"}, PWRITE, v.wr);
        chk({tag, "_pwdata"}, PWDATA, v.wdata);

        lat = 1;
        acc = 0;
        got = 1'b0;
        stable_ok = 1'b1;
        for (int c = 0; c < 60 && !got; c++) begin
            if (rsp_valid_o) begin
                got = 1'b1;
            end else begin
                if (PENABLE) begin
                    acc++;
                    if (!PSEL || PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata)
                        stable_ok = 1'b0;
                end
                PREADY  = PENABLE && (acc == v.waits + 1);
                PRDATA  = PREADY ? v.prdata : $urandom;
                PSLVERR = PREADY ? v.slverr : 1'($urandom_range(0, 1));
                step();
                lat++;
            end
        end
        PREADY = 1'b0;

        if (!got) begin
            chk({tag, "_rsp_arrival"}, 0, 1);
            void'(exp_q.pop_front());
            do_reset();
            return;
        end

        ex = exp_q.pop_front();
        chk({tag, "_apb_stable"}, stable_ok, 1);
        chk({tag, "_access_cycles"}, acc, model_access_cycles(v));
        chk({tag, "_rsp_latency"}, lat, 2 + model_access_cycles(v));
        chk({tag, "_rdata"}, rsp_rdata_o, ex[DW+1:2]);
        chk({tag, "_err"}, rsp_err_o, ex[1]);
        chk({tag, "_timeout"}, rsp_timeout_o, ex[0]);
        chk({tag, "_resp_strobes"}, {PSEL, PENABLE, cmd_ready_o}, 3'b000);

        // Response back-pressure: payload must hold, and a new command must wait.
        h_rd = rsp_rdata_o; h_err = rsp_err_o; h_to = rsp_timeout_o;
        stable_ok = 1'b1;
        cmd_valid_i = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            PRDATA  = $urandom;
            PSLVERR = 1'b1;
            step();
            if (!rsp_valid_o || rsp_rdata_o !== h_rd || rsp_err_o !== h_err ||
                rsp_timeout_o !== h_to || cmd_ready_o || PSEL || PENABLE)
                stable_ok = 1'b0;
        end
        if (v.hold > 0) chk({tag, "_rsp_hold"}, stable_ok, 1);
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk({tag, "_after_rsp"}, {rsp_valid_o, cmd_ready_o, PSEL, PENABLE}, 4'b0100);
        chk({tag, "_idle_paddr_hold"}, PADDR, v.addr);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        vec_t          rv;
        logic          no_rsp;
        logic [DW-1:0] zero_d;
        zero_d = '0;

        PRESETn = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
        rsp_ready_i = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        tbl[0] = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0,  32'hAAAA_5555, 1'b0, 0, 32'h0,         1'b0, 1'b0);
        tbl[1] = mk(1'b0, 32'h0000_0004, 32'h0,         3,  32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 32'h0000_0008, 32'h0,         0,  32'hCAFE_F00D, 1'b1, 0, 32'hCAFE_F00D, 1'b1, 1'b0);
        tbl[3] = mk(1'b0, 32'h0000_0020, 32'h0,         20, 32'h7777_7777, 1'b0, 0, 32'h0,         1'b1, 1'b1);
        tbl[4] = mk(1'b0, 32'h0000_0024, 32'h0,         15, 32'h0BAD_C0DE, 1'b0, 0, 32'h0BAD_C0DE, 1'b0, 1'b0);
        tbl[5] = mk(1'b1, 32'h0000_0028, 32'h1111_2222, 16, 32'h3333_4444, 1'b0, 0, 32'h0,         1'b1, 1'b1);
        tbl[6] = mk(1'b0, 32'h0000_002C, 32'h0,         1,  32'h55AA_55AA, 1'b0, 5, 32'h55AA_55AA, 1'b0, 1'b0);
        tbl[7] = mk(1'b1, 32'h0000_0030, 32'h9999_8888, 2,  32'hFFFF_FFFF, 1'b1, 2, 32'h0,         1'b1, 1'b0);

        // Reset values
        step();
        step();
        chk("reset_strobes", {PSEL, PENABLE, PWRITE, rsp_valid_o}, 4'b0000);
        chk("reset_paddr", PADDR, 0);
        chk("reset_pwdata", PWDATA, 0);
        chk("reset_rsp", {rsp_rdata_o, rsp_err_o, rsp_timeout_o}, 0);
        PRESETn = 1'b1;
        step();
        chk("reset_cmd_ready", cmd_ready_o, 1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_xfer($sformatf("vec%0d", i), tbl[i], {tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_to});
        end

        // Randomized transfers against the reference model
        for (int i = 0; i < 14; i++) begin
            rv = mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 18),
                    $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    zero_d, 1'b0, 1'b0);
            run_xfer($sformatf("rnd%0d", i), rv, model(rv));
        end

        // Reset in the middle of ACCESS abandons the transfer
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1;
        cmd_addr_i = 32'hABCD_0000; cmd_wdata_i = 32'h1357_9BDF;
        PREADY = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        step();
        step();
        chk("rst_mid_in_access", PENABLE, 1);
        PRESETn = 1'b0;
        step();
        chk("rst_mid_strobes", {PSEL, PENABLE, PWRITE, rsp_valid_o}, 4'b0000);
        chk("rst_mid_paddr", PADDR, 0);
        chk("rst_mid_pwdata", PWDATA, 0);
        PRESETn = 1'b1;
        step();
        chk("rst_mid_cmd_ready", cmd_ready_o, 1);
        no_rsp = 1'b1;
        for (int c = 0; c < 20; c++) begin
            PREADY = 1'b1;
            step();
            if (rsp_valid_o || PSEL) no_rsp = 1'b0;
        end
        PREADY = 1'b0;
        chk("rst_mid_no_response", no_rsp, 1);

        // A normal transfer still works after the abandoned one
        run_xfer("post_rst", tbl[1], {tbl[1].e_rdata, tbl[1].e_err, tbl[1].e_to});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
